// File: rtl/dct_transpose_buffer_pkg.sv
// Shared JPEG pipeline definitions used by the transpose buffer.
//   JPEG_DW  : default sample width in bits (signed two's complement)
//   sample_t : one signed sample
//   vec_t    : one 8-sample block row or column, element [i] is position i
//   idx_inc  : wrapping increment of a 0..7 row/column index
package dct_transpose_buffer_pkg;

  localparam int JPEG_DW = 8;

  typedef logic signed [JPEG_DW-1:0] sample_t;
  typedef sample_t [7:0] vec_t;

  function automatic logic [2:0] idx_inc(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/dct_transpose_bank.sv
// One 8x8 sample register bank: rows are written whole, columns are read
// whole through a combinational mux.
//   clk      in   clock
//   wr_en    in   write wr_data into row wr_row this cycle
//   wr_row   in   row being written (0..7)
//   wr_data  in   row samples, wr_data[c] lands in column c
//   rd_col   in   column being read (0..7)
//   rd_data  out  column samples, rd_data[r] comes from row r
module transpose_bank
  import dct_transpose_buffer_pkg::*;
#(
  parameter int DW = JPEG_DW
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [2:0]          wr_row,
  input  logic [7:0][DW-1:0]  wr_data,
  input  logic [2:0]          rd_col,
  output logic [7:0][DW-1:0]  rd_data
);

  // Sample storage has no reset: contents are only observed once the
  // owning bank has been completely written.
  logic [7:0][7:0][DW-1:0] mem;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < 8; r++) begin
      rd_data[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the JPEG ISP (row transfers) and
// the first, column-oriented DCT pass (column transfers).
//   clk       in   single clock
//   reset     in   synchronous active-high reset
//   di        in   block row, di[c] is column c
//   di_valid  in   input row valid
//   di_hold   out  back-pressure to the ISP (registered state only)
//   di_cnt    in   row index claimed by the ISP, checked against wr_row
//   dq        out  block column, dq[r] is row r
//   dq_valid  out  output column valid
//   dq_hold   in   back-pressure from the DCT
//   dq_cnt    out  column index of the presented column
//   seq_err   out  sticky: an accepted row carried an unexpected di_cnt
module dct_transpose_buffer
  import dct_transpose_buffer_pkg::*;
#(
  parameter int DW = JPEG_DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0][DW-1:0]  di,
  input  logic                di_valid,
  output logic                di_hold,
  input  logic [2:0]          di_cnt,
  output logic [7:0][DW-1:0]  dq,
  output logic                dq_valid,
  input  logic                dq_hold,
  output logic [2:0]          dq_cnt,
  output logic                seq_err
);

  logic             wr_sel;
  logic             rd_sel;
  logic [1:0]       full;
  logic [2:0]       wr_row;
  logic [2:0]       rd_col;
  logic             in_xfer;
  logic             out_xfer;
  logic [7:0][DW-1:0] rd_data0;
  logic [7:0][DW-1:0] rd_data1;

  // Handshakes depend only on the full flags, so dq_hold never reaches
  // di_hold combinationally.
  assign di_hold  = full[wr_sel];
  assign dq_valid = full[rd_sel];
  assign in_xfer  = di_valid && !di_hold;
  assign out_xfer = dq_valid && !dq_hold;
  assign dq_cnt   = rd_col;
  assign dq       = rd_sel ? rd_data1 : rd_data0;

  transpose_bank #(.DW(DW)) u_bank0 (
    .clk     (clk),
    .wr_en   (in_xfer && !wr_sel),
    .wr_row  (wr_row),
    .wr_data (di),
    .rd_col  (rd_col),
    .rd_data (rd_data0)
  );

  transpose_bank #(.DW(DW)) u_bank1 (
    .clk     (clk),
    .wr_en   (in_xfer && wr_sel),
    .wr_row  (wr_row),
    .wr_data (di),
    .rd_col  (rd_col),
    .rd_data (rd_data1)
  );

  // Writer and reader always own different banks while both are active, so
  // setting one full flag and clearing the other in the same cycle is safe.
  // di_cnt is only checked, never used as the write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      full    <= 2'b00;
      wr_row  <= 3'd0;
      rd_col  <= 3'd0;
      seq_err <= 1'b0;
    end else begin
      if (in_xfer) begin
        wr_row <= idx_inc(wr_row);
        if (di_cnt != wr_row) begin
          seq_err <= 1'b1;
        end
        if (wr_row == 3'd7) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (out_xfer) begin
        rd_col <= idx_inc(rd_col);
        if (rd_col == 3'd7) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer: directed block patterns with
// hand-computed columns, back-pressure and sequence-error cases, reset in
// mid-block, and a randomized handshake run against a transpose scoreboard.
module tb_dct_transpose_buffer;

  logic             clk;
  logic             reset;
  logic [7:0][7:0]  di;
  logic             di_valid;
  logic             di_hold;
  logic [2:0]       di_cnt;
  logic [7:0][7:0]  dq;
  logic             dq_valid;
  logic             dq_hold;
  logic [2:0]       dq_cnt;
  logic             seq_err;

  int cmpCount;
  int errCount;

  dct_transpose_buffer #(.DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .di       (di),
    .di_valid (di_valid),
    .di_hold  (di_hold),
    .di_cnt   (di_cnt),
    .dq       (dq),
    .dq_valid (dq_valid),
    .dq_hold  (dq_hold),
    .dq_cnt   (dq_cnt),
    .seq_err  (seq_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] row,
                               input logic [2:0] cnt, input logic hold);
    di_valid = v;
    di       = row;
    di_cnt   = cnt;
    dq_hold  = hold;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pattern block b: sample (r,c) = 64*b + 8*r + c.
  function automatic logic [63:0] patRow(input int b, input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(b*64 + r*8 + c);
    return v;
  endfunction

  function automatic logic [63:0] patCol(input int b, input int k);
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[r*8 +: 8] = 8'(b*64 + r*8 + k);
    return v;
  endfunction

  logic [2:0]  badCnt [8];
  logic [63:0] rowBuf [8];
  logic [63:0] pendRow;
  logic [63:0] colVal;
  logic [71:0] expQ [$];
  logic [71:0] expItem;
  int inRow, blocksSent, outs, cyc;
  logic v, h;

  initial begin
    cmpCount = 0;
    errCount = 0;
    reset    = 1'b1;
    applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);

    // ---- reset state ----
    resetDut();
    checkOutput("rst_dq_valid", 72'(dq_valid), 72'(0));
    checkOutput("rst_di_hold",  72'(di_hold),  72'(0));
    checkOutput("rst_dq_cnt",   72'(dq_cnt),   72'(0));
    checkOutput("rst_seq_err",  72'(seq_err),  72'(0));

    // ---- single block, no hold ----
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, patRow(0, r), 3'(r), 1'b0);
      checkOutput("t1_pre_valid", 72'(dq_valid), 72'(0));
      checkOutput("t1_di_hold", 72'(di_hold), 72'(0));
      tick();
    end
    applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t1_valid", 72'(dq_valid), 72'(1));
      checkOutput("t1_cnt", 72'(dq_cnt), 72'(k));
      checkOutput("t1_col", 72'(dq), 72'(patCol(0, k)));
      tick();
    end
    checkOutput("t1_post_valid", 72'(dq_valid), 72'(0));
    checkOutput("t1_seq_err", 72'(seq_err), 72'(0));

    // ---- four back-to-back blocks, no hold ----
    resetDut();
    for (int i = 0; i < 40; i++) begin
      if (i < 32) applyStimulus(1'b1, patRow(i/8, i%8), 3'(i%8), 1'b0);
      else        applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
      if (i < 32) checkOutput("t2_di_hold", 72'(di_hold), 72'(0));
      checkOutput("t2_valid", 72'(dq_valid), 72'(i >= 8));
      if (i >= 8) begin
        checkOutput("t2_cnt", 72'(dq_cnt), 72'((i-8)%8));
        checkOutput("t2_col", 72'(dq), 72'(patCol((i-8)/8, (i-8)%8)));
      end
      tick();
    end
    checkOutput("t2_post_valid", 72'(dq_valid), 72'(0));

    // ---- output held 20 cycles: both banks fill, then drain ----
    resetDut();
    for (int i = 0; i < 36; i++) begin
      if (i < 16)       applyStimulus(1'b1, patRow(i/8, i%8), 3'(i%8), i < 20);
      else if (i <= 28) applyStimulus(1'b1, patRow(2, 0), 3'd0, i < 20);
      else              applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
      checkOutput("t3_di_hold", 72'(di_hold), 72'(i >= 16 && i <= 27));
      checkOutput("t3_valid", 72'(dq_valid), 72'(i >= 8));
      if (i >= 8 && i < 20) begin
        checkOutput("t3_held_cnt", 72'(dq_cnt), 72'(0));
        checkOutput("t3_held_col", 72'(dq), 72'(patCol(0, 0)));
      end else if (i >= 20) begin
        checkOutput("t3_cnt", 72'(dq_cnt), 72'((i-20)%8));
        checkOutput("t3_col", 72'(dq), 72'(patCol((i-20)/8, (i-20)%8)));
      end
      tick();
    end
    checkOutput("t3_post_valid", 72'(dq_valid), 72'(0));

    // ---- row sequence error: di_cnt 0,1,3,3,4,5,6,7 ----
    resetDut();
    badCnt = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, patRow(1, r), badCnt[r], 1'b0);
      checkOutput("t4_seq_err", 72'(seq_err), 72'(r >= 3));
      tick();
    end
    applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t4_seq_sticky", 72'(seq_err), 72'(1));
      checkOutput("t4_col", 72'(dq), 72'(patCol(1, k)));
      tick();
    end

    // ---- reset with one full block and a 5-row partial block ----
    resetDut();
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, patRow(0, r), 3'(r), 1'b1);
      tick();
    end
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b1, patRow(1, r), (r == 1) ? 3'd5 : 3'(r), 1'b1);
      tick();
    end
    checkOutput("t5_pre_valid", 72'(dq_valid), 72'(1));
    checkOutput("t5_pre_seq_err", 72'(seq_err), 72'(1));
    applyStimulus(1'b0, 64'd0, 3'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_rst_valid", 72'(dq_valid), 72'(0));
    checkOutput("t5_rst_di_hold", 72'(di_hold), 72'(0));
    checkOutput("t5_rst_seq_err", 72'(seq_err), 72'(0));
    checkOutput("t5_rst_cnt", 72'(dq_cnt), 72'(0));
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, patRow(3, r), 3'(r), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 64'd0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t5_valid", 72'(dq_valid), 72'(1));
      checkOutput("t5_col", 72'({5'd0, dq_cnt, dq}), {5'd0, 3'(k), patCol(3, k)});
      tick();
    end
    checkOutput("t5_seq_err", 72'(seq_err), 72'(0));

    // ---- random handshakes, 100 blocks, scoreboard of expected columns ----
    resetDut();
    inRow      = 0;
    blocksSent = 0;
    outs       = 0;
    cyc        = 0;
    pendRow    = {$urandom, $urandom};
    while (cyc < 20000 && !(blocksSent == 100 && expQ.size() == 0)) begin
      v = (blocksSent < 100) && ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 9) < 3);
      applyStimulus(v, pendRow, 3'(inRow), h);
      if (di_valid && !di_hold) begin
        rowBuf[inRow] = pendRow;
        inRow++;
        pendRow = {$urandom, $urandom};
        if (inRow == 8) begin
          for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 8; r++) colVal[r*8 +: 8] = rowBuf[r][k*8 +: 8];
            expQ.push_back({5'd0, 3'(k), colVal});
          end
          inRow = 0;
          blocksSent++;
        end
      end
      if (dq_valid && !dq_hold) begin
        checkOutput("rnd_expected_any", 72'(expQ.size() != 0), 72'(1));
        if (expQ.size() != 0) begin
          expItem = expQ.pop_front();
          checkOutput("rnd_col", {5'd0, dq_cnt, dq}, expItem);
        end
        outs++;
      end
      tick();
      cyc++;
    end
    checkOutput("rnd_blocks_sent", 72'(blocksSent), 72'(100));
    checkOutput("rnd_out_count", 72'(outs), 72'(800));
    checkOutput("rnd_drained", 72'(expQ.size()), 72'(0));
    checkOutput("rnd_seq_err", 72'(seq_err), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
